// File: rtl/aes_uart_framer_if.sv
// Framer-side bus bundle: UART RX/TX byte signals and the 128-bit block handshakes.
// The master modport is the framer's view; slave is the surrounding UART/AES side.
interface aes_uart_framer_if #(
    parameter int BYTES_PER_BLOCK = 16
);
    localparam int BLK_W = BYTES_PER_BLOCK * 8;
    localparam int CNT_W = $clog2(BYTES_PER_BLOCK + 1);

    logic             rx_valid;
    logic [7:0]       rx_byte;
    logic [BLK_W-1:0] blk_out_data;
    logic             blk_out_valid;
    logic             blk_out_ready;
    logic [BLK_W-1:0] blk_in_data;
    logic             blk_in_valid;
    logic             blk_in_ready;
    logic             tx_start;
    logic [7:0]       tx_byte;
    logic             tx_busy;
    logic             tx_done;
    logic [CNT_W-1:0] rx_count;
    logic             overrun;

    modport master (
        input  rx_valid, rx_byte, blk_out_ready, blk_in_data, blk_in_valid, tx_busy, tx_done,
        output blk_out_data, blk_out_valid, blk_in_ready, tx_start, tx_byte, rx_count, overrun
    );

    modport slave (
        output rx_valid, rx_byte, blk_out_ready, blk_in_data, blk_in_valid, tx_busy, tx_done,
        input  blk_out_data, blk_out_valid, blk_in_ready, tx_start, tx_byte, rx_count, overrun
    );
endinterface

// File: rtl/aes_uart_framer.sv
// UART byte <-> AES block framer: RX packs bytes into a block, TX serialises a block into bytes.
// Define FRAMER_TIMEOUT_EN to discard a partial RX block after RX_TIMEOUT idle cycles.
module aes_uart_framer #(
    parameter int BYTES_PER_BLOCK = 16,
    parameter int RX_TIMEOUT      = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    aes_uart_framer_if.master bus
);
    localparam int NB    = BYTES_PER_BLOCK;
    localparam int CNT_W = $clog2(NB + 1);
    localparam int IDX_W = $clog2(NB);

    typedef enum logic       {RX_FILL, RX_HOLD} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_t;

    // ---------------- receive side ----------------
    rx_state_t          rx_state, rx_next;
    logic [NB-1:0][7:0] rx_blk;
    logic [CNT_W-1:0]   rx_cnt, rx_cnt_next;
    logic [IDX_W-1:0]   rx_lane;
    logic               rx_wr, rx_drop, rx_flush, ovr;

    always_ff @(posedge clk) begin
        if (reset) rx_state <= RX_FILL;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next     = rx_state;
        rx_wr       = 1'b0;
        rx_drop     = 1'b0;
        rx_lane     = IDX_W'(NB - 1);
        rx_cnt_next = rx_cnt;
        case (rx_state)
            RX_FILL: begin
                if (bus.rx_valid) begin
                    rx_wr       = 1'b1;
                    rx_lane     = IDX_W'(NB - 1) - rx_cnt[IDX_W-1:0];
                    rx_cnt_next = rx_cnt + CNT_W'(1);
                    if (rx_cnt == CNT_W'(NB - 1)) rx_next = RX_HOLD;
                end else if (rx_flush) begin
                    rx_cnt_next = '0;
                end
            end
            RX_HOLD: begin
                // A byte arriving with the handshake starts the next block instead of overrunning.
                if (bus.blk_out_ready) begin
                    rx_next     = RX_FILL;
                    rx_wr       = bus.rx_valid;
                    rx_cnt_next = bus.rx_valid ? CNT_W'(1) : '0;
                end else if (bus.rx_valid) begin
                    rx_drop = 1'b1;
                end
            end
            default: rx_next = RX_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_blk <= '0;
            rx_cnt <= '0;
            ovr    <= 1'b0;
        end else begin
            if (rx_wr)   rx_blk[rx_lane] <= bus.rx_byte;
            if (rx_drop) ovr <= 1'b1;
            rx_cnt <= rx_cnt_next;
        end
    end

`ifdef FRAMER_TIMEOUT_EN
    localparam int TMR_W = $clog2(RX_TIMEOUT + 1);
    logic [TMR_W-1:0] rx_tmr;
    logic             tmr_run;

    assign tmr_run  = (rx_state == RX_FILL) && (rx_cnt != '0) && !bus.rx_valid;
    assign rx_flush = tmr_run && (rx_tmr == TMR_W'(RX_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || !tmr_run || rx_flush) rx_tmr <= '0;
        else                               rx_tmr <= rx_tmr + TMR_W'(1);
    end
`else
    assign rx_flush = 1'b0;
`endif

    assign bus.blk_out_data  = rx_blk;
    assign bus.blk_out_valid = (rx_state == RX_HOLD);
    assign bus.rx_count      = rx_cnt;
    assign bus.overrun       = ovr;

    // ---------------- transmit side ----------------
    tx_state_t          tx_state, tx_next;
    logic [NB-1:0][7:0] tx_sr;
    logic [IDX_W-1:0]   tx_idx;
    logic               tx_load, tx_adv, rdy_q;

    always_ff @(posedge clk) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        tx_load = 1'b0;
        tx_adv  = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (rdy_q && bus.blk_in_valid) begin
                    tx_load = 1'b1;
                    tx_next = TX_SEND;
                end
            end
            TX_SEND: if (!bus.tx_busy) tx_next = TX_WAIT;
            TX_WAIT: begin
                if (bus.tx_done) begin
                    if (tx_idx == IDX_W'(NB - 1)) begin
                        tx_next = TX_IDLE;
                    end else begin
                        tx_adv  = 1'b1;
                        tx_next = TX_SEND;
                    end
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // Ready is registered so it stays low through reset and rises one cycle after it.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_sr  <= '0;
            tx_idx <= '0;
            rdy_q  <= 1'b0;
        end else begin
            if (tx_load) begin
                tx_sr  <= bus.blk_in_data;
                tx_idx <= '0;
            end else if (tx_adv) begin
                tx_sr  <= {tx_sr[NB-2:0], 8'h00};
                tx_idx <= tx_idx + IDX_W'(1);
            end
            rdy_q <= (tx_next == TX_IDLE);
        end
    end

    assign bus.tx_start     = (tx_state == TX_SEND) && !bus.tx_busy && !reset;
    assign bus.tx_byte      = tx_sr[NB-1];
    assign bus.blk_in_ready = rdy_q;
endmodule

// File: tb/tb_aes_uart_framer.sv
// Directed bench for aes_uart_framer: RX table vectors plus hand-written TX/reset/timeout sequences.
module tb_aes_uart_framer;
    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    aes_uart_framer_if #(.BYTES_PER_BLOCK(16)) bus ();

    aes_uart_framer #(.BYTES_PER_BLOCK(16), .RX_TIMEOUT(20)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    typedef struct {
        logic         rv;
        logic [7:0]   rb;
        logic         rdy;
        logic         e_vld;
        logic [4:0]   e_cnt;
        logic         e_ovr;
        logic         chk_d;
        logic [127:0] e_d;
    } vec_t;

    vec_t vt[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rv, input logic [7:0] rb, input logic rdy, input logic e_vld,
                       input logic [4:0] e_cnt, input logic e_ovr, input logic chk_d,
                       input logic [127:0] e_d);
        vec_t v;
        v.rv = rv; v.rb = rb; v.rdy = rdy; v.e_vld = e_vld;
        v.e_cnt = e_cnt; v.e_ovr = e_ovr; v.chk_d = chk_d; v.e_d = e_d;
        vt.push_back(v);
    endtask

    task automatic chk_reset_outputs;
        chk("rst_data",  bus.blk_out_data, '0);
        chk("rst_valid", bus.blk_out_valid, 0);
        chk("rst_ready", bus.blk_in_ready, 0);
        chk("rst_start", bus.tx_start, 0);
        chk("rst_byte",  bus.tx_byte, 0);
        chk("rst_count", bus.rx_count, 0);
        chk("rst_ovr",   bus.overrun, 0);
    endtask

    task automatic send_bytes(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_byte  = base + 8'(i);
            tick;
        end
        bus.rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nst, tmr, last_done, rdy_cyc, bad_rdy, starts;

        reset = 1'b1;
        bus.rx_valid = 1'b0; bus.rx_byte = '0; bus.blk_out_ready = 1'b0;
        bus.blk_in_data = '0; bus.blk_in_valid = 1'b0;
        bus.tx_busy = 1'b0; bus.tx_done = 1'b0;

        // stimulus table: full block with ready, same-cycle handshake + byte, then overrun
        for (int i = 0; i < 16; i++)
            add(1, 8'(i), 1, i == 15, 5'(i + 1), 0, i == 15, 128'h000102030405060708090A0B0C0D0E0F);
        add(0, 8'h00, 1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 16; i++)
            add(1, 8'h10 + 8'(i), 0, i == 15, 5'(i + 1), 0, i == 15, 128'h101112131415161718191A1B1C1D1E1F);
        add(1, 8'h5C, 1, 0, 1, 0, 1, 128'h5C1112131415161718191A1B1C1D1E1F);
        for (int i = 0; i < 15; i++)
            add(1, 8'h60 + 8'(i), 0, i == 14, 5'(i + 2), 0, i == 14, 128'h5C606162636465666768696A6B6C6D6E);
        add(1, 8'hAA, 0, 1, 16, 1, 1, 128'h5C606162636465666768696A6B6C6D6E);
        add(0, 8'h00, 0, 1, 16, 1, 1, 128'h5C606162636465666768696A6B6C6D6E);
        add(0, 8'h00, 1, 0, 0, 1, 0, '0);
        add(0, 8'h00, 0, 0, 0, 1, 0, '0);

        tick; tick;
        chk_reset_outputs();
        reset = 1'b0;
        tick;
        chk("ready_after_reset", bus.blk_in_ready, 1);

        foreach (vt[k]) begin
            bus.rx_valid = vt[k].rv;
            bus.rx_byte  = vt[k].rb;
            bus.blk_out_ready = vt[k].rdy;
            tick;
            chk($sformatf("v%0d_valid", k), bus.blk_out_valid, vt[k].e_vld);
            chk($sformatf("v%0d_count", k), bus.rx_count, vt[k].e_cnt);
            chk($sformatf("v%0d_ovr", k), bus.overrun, vt[k].e_ovr);
            if (vt[k].chk_d) chk($sformatf("v%0d_data", k), bus.blk_out_data, vt[k].e_d);
        end
        bus.rx_valid = 1'b0;
        bus.blk_out_ready = 1'b0;

        // TX: full block with a UART model answering tx_done 10 cycles after each tx_start
        bus.blk_in_data  = 128'h00112233445566778899AABBCCDDEEFF;
        bus.blk_in_valid = 1'b1;
        tick;
        bus.blk_in_valid = 1'b0;
        chk("tx_accept_ready", bus.blk_in_ready, 0);
        nst = 0; tmr = 0; last_done = -1; rdy_cyc = -1; bad_rdy = 0;
        for (int c = 0; c < 400 && rdy_cyc < 0; c++) begin
            if (bus.blk_in_ready) begin
                if (nst == 16) rdy_cyc = c;
                else bad_rdy++;
            end
            bus.tx_done = 1'b0;
            if (tmr > 0) begin
                tmr--;
                if (tmr == 0) begin
                    bus.tx_done = 1'b1;
                    last_done = c;
                end
            end
            if (bus.tx_start) begin
                chk($sformatf("tx_byte%0d", nst), bus.tx_byte, 8'(nst * 8'h11));
                chk($sformatf("tx_lat%0d", nst), c - last_done, 1);
                nst++;
                tmr = 10;
            end
            tick;
        end
        bus.tx_done = 1'b0;
        chk("tx_pulses", nst, 16);
        chk("tx_ready_low", bad_rdy, 0);
        chk("tx_ready_rise", rdy_cyc - last_done, 1);

        // TX: transmitter busy for 50 cycles after acceptance
        bus.tx_busy = 1'b1;
        bus.blk_in_valid = 1'b1;
        tick;
        bus.blk_in_valid = 1'b0;
        starts = 0;
        repeat (50) begin
            if (bus.tx_start) starts++;
            tick;
        end
        chk("busy_no_start", starts, 0);
        bus.tx_busy = 1'b0;
        #1;
        chk("busy_start", bus.tx_start, 1);
        chk("busy_byte", bus.tx_byte, 8'h00);
        tick;
        starts = 0;
        repeat (10) begin
            if (bus.tx_start) starts++;
            tick;
        end
        chk("busy_single_pulse", starts, 0);

        // reset mid-operation: TX on byte 1, five RX bytes stored
        bus.tx_done = 1'b1;
        tick;
        bus.tx_done = 1'b0;
        chk("mid_start", bus.tx_start, 1);
        chk("mid_byte", bus.tx_byte, 8'h11);
        tick;
        send_bytes(5, 8'h30);
        chk("mid_count", bus.rx_count, 5);
        reset = 1'b1;
        tick;
        chk_reset_outputs();
        reset = 1'b0;
        tick;
        chk("post_rst_count", bus.rx_count, 0);
        chk("post_rst_start", bus.tx_start, 0);
        chk("post_rst_ready", bus.blk_in_ready, 1);

        // partial block followed by silence
        send_bytes(3, 8'h40);
        repeat (19) tick;
        chk("idle19_count", bus.rx_count, 3);
        tick;
`ifdef FRAMER_TIMEOUT_EN
        chk("timeout_count", bus.rx_count, 0);
`else
        chk("no_timeout_count", bus.rx_count, 3);
`endif
        repeat (5) tick;
        chk("idle_valid", bus.blk_out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
